// File: rtl/parking_ctrl.sv
// Three-slot parking controller: grants slots on entry, bills elapsed time on exit,
// and drives an external slot store that holds entry times and charged fees.
module parking_ctrl #(
    parameter int unsigned RATE      = 2,
    parameter int unsigned MIN_UNITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] time_now,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [1:0] exit_car,
    output logic [1:0] mem_car_sel,
    output logic       mem_write_entry,
    output logic       mem_write_cost,
    output logic [9:0] mem_entry_time_in,
    output logic [9:0] mem_cost_in,
    input  logic [9:0] mem_entry_time_out,
    output logic       entry_ack,
    output logic       entry_nack,
    output logic [1:0] granted_car,
    output logic       exit_ack,
    output logic       exit_nack,
    output logic [9:0] fee_out,
    output logic [2:0] occupancy,
    output logic       full,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ENTRY_WR,
        EXIT_RD,
        EXIT_CALC,
        EXIT_WR,
        DONE
    } state_t;

    state_t     state;
    logic       pend_entry;
    logic       pend_exit;
    logic [1:0] pend_car;
    logic [1:0] cur_car;
    logic [9:0] t_entry;
    logic [9:0] t_exit;

    logic [1:0]  free_slot;
    logic [2:0]  cur_mask;
    logic [3:0]  occ_ext;
    logic        exit_valid;
    logic [9:0]  elapsed;
    logic [31:0] units;
    logic [63:0] product;
    logic [9:0]  fee_calc;

    // Lowest-index vacant slot; only consulted when the lot is not full.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        free_slot = 2'd0;
        if (!occupancy[0])
            free_slot = 2'd0;
        else if (!occupancy[1])
            free_slot = 2'd1;
        else if (!occupancy[2])
            free_slot = 2'd2;
    end

    // Index 3 maps onto a permanently vacant bit, so it is rejected like an empty slot.
    assign occ_ext    = {1'b0, occupancy};
    assign exit_valid = occ_ext[pend_car];
    assign cur_mask   = 3'b001 << cur_car;

    // Billing: modulo-1024 elapsed time, minimum charge, saturating fee.
    assign elapsed = t_exit - t_entry;

    always_comb begin
        units = {22'd0, elapsed};
        if (units < MIN_UNITS)
            units = MIN_UNITS;
        product  = 64'(units) * 64'(RATE);
        fee_calc = (product > 64'd1023) ? 10'd1023 : product[9:0];
    end

    // Outputs are registered alongside the state they belong to, so each pulse
    // is set on the edge entering its state and cleared by the default on the next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            pend_entry        <= 1'b0;
            pend_exit         <= 1'b0;
            pend_car          <= 2'd0;
            cur_car           <= 2'd0;
            t_entry           <= 10'd0;
            t_exit            <= 10'd0;
            mem_car_sel       <= 2'd0;
            mem_write_entry   <= 1'b0;
            mem_write_cost    <= 1'b0;
            mem_entry_time_in <= 10'd0;
            mem_cost_in       <= 10'd0;
            entry_ack         <= 1'b0;
            entry_nack        <= 1'b0;
            granted_car       <= 2'd0;
            exit_ack          <= 1'b0;
            exit_nack         <= 1'b0;
            fee_out           <= 10'd0;
            occupancy         <= 3'b000;
            full              <= 1'b0;
            busy              <= 1'b0;
        end else begin
            entry_ack       <= 1'b0;
            entry_nack      <= 1'b0;
            exit_ack        <= 1'b0;
            exit_nack       <= 1'b0;
            mem_write_entry <= 1'b0;
            mem_write_cost  <= 1'b0;

            if (entry_req && !pend_entry)
                pend_entry <= 1'b1;
            if (exit_req && !pend_exit) begin
                pend_exit <= 1'b1;
                pend_car  <= exit_car;
            end

            // NOTE: the clears below come after the captures above; with non-blocking
            // assignments the last one wins, so a same-edge request is dropped.
            case (state)
                IDLE: begin
                    if (pend_exit) begin
                        if (!exit_valid) begin
                            exit_nack <= 1'b1;
                            pend_exit <= 1'b0;
                        end else begin
                            state       <= EXIT_RD;
                            busy        <= 1'b1;
                            cur_car     <= pend_car;
                            mem_car_sel <= pend_car;
                        end
                    end else if (pend_entry) begin
                        if (full) begin
                            entry_nack <= 1'b1;
                            pend_entry <= 1'b0;
                        end else begin
                            state             <= ENTRY_WR;
                            busy              <= 1'b1;
                            cur_car           <= free_slot;
                            mem_car_sel       <= free_slot;
                            mem_write_entry   <= 1'b1;
                            mem_entry_time_in <= time_now;
                        end
                    end
                end

                ENTRY_WR: begin
                    occupancy   <= occupancy | cur_mask;
                    full        <= &(occupancy | cur_mask);
                    entry_ack   <= 1'b1;
                    granted_car <= cur_car;
                    pend_entry  <= 1'b0;
                    state       <= DONE;
                end

                EXIT_RD: begin
                    t_entry <= mem_entry_time_out;
                    t_exit  <= time_now;
                    state   <= EXIT_CALC;
                end

                EXIT_CALC: begin
                    mem_cost_in    <= fee_calc;
                    mem_write_cost <= 1'b1;
                    state          <= EXIT_WR;
                end

                EXIT_WR: begin
                    occupancy <= occupancy & ~cur_mask;
                    full      <= 1'b0;
                    exit_ack  <= 1'b1;
                    fee_out   <= mem_cost_in;
                    pend_exit <= 1'b0;
                    state     <= DONE;
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_ctrl.sv
// Bench for parking_ctrl: directed scenarios then random entry/exit traffic, checked
// against a slot-level model; a second instance with RATE=4 exercises fee saturation.
module tb_parking_ctrl;

    localparam int MIN_UNITS = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] time_now;
    logic       entry_req;
    logic       exit_req;
    logic [1:0] exit_car;

    logic [1:0] mem_car_sel, granted_car;
    logic       mem_write_entry, mem_write_cost, entry_ack, entry_nack, exit_ack, exit_nack, full, busy;
    logic [9:0] mem_entry_time_in, mem_cost_in, mem_entry_time_out, fee_out;
    logic [2:0] occupancy;

    logic [1:0] mem_car_sel_4, granted_car_4;
    logic       mem_write_entry_4, mem_write_cost_4, entry_ack_4, entry_nack_4, exit_ack_4, exit_nack_4, full_4, busy_4;
    logic [9:0] mem_entry_time_in_4, mem_cost_in_4, mem_entry_time_out_4, fee_out_4;
    logic [2:0] occupancy_4;

    always #5 clk = ~clk;

    parking_ctrl dut (
        .clk(clk), .reset(reset), .time_now(time_now),
        .entry_req(entry_req), .exit_req(exit_req), .exit_car(exit_car),
        .mem_car_sel(mem_car_sel), .mem_write_entry(mem_write_entry), .mem_write_cost(mem_write_cost),
        .mem_entry_time_in(mem_entry_time_in), .mem_cost_in(mem_cost_in),
        .mem_entry_time_out(mem_entry_time_out),
        .entry_ack(entry_ack), .entry_nack(entry_nack), .granted_car(granted_car),
        .exit_ack(exit_ack), .exit_nack(exit_nack), .fee_out(fee_out),
        .occupancy(occupancy), .full(full), .busy(busy)
    );

    parking_ctrl #(.RATE(4), .MIN_UNITS(1)) dut4 (
        .clk(clk), .reset(reset), .time_now(time_now),
        .entry_req(entry_req), .exit_req(exit_req), .exit_car(exit_car),
        .mem_car_sel(mem_car_sel_4), .mem_write_entry(mem_write_entry_4), .mem_write_cost(mem_write_cost_4),
        .mem_entry_time_in(mem_entry_time_in_4), .mem_cost_in(mem_cost_in_4),
        .mem_entry_time_out(mem_entry_time_out_4),
        .entry_ack(entry_ack_4), .entry_nack(entry_nack_4), .granted_car(granted_car_4),
        .exit_ack(exit_ack_4), .exit_nack(exit_nack_4), .fee_out(fee_out_4),
        .occupancy(occupancy_4), .full(full_4), .busy(busy_4)
    );

    // External slot stores: synchronous write, combinational read.
    logic [9:0] store_t  [4] = '{default: 10'd0};
    logic [9:0] store_t4 [4] = '{default: 10'd0};
    always @(posedge clk) if (mem_write_entry)   store_t[mem_car_sel]    <= mem_entry_time_in;
    always @(posedge clk) if (mem_write_entry_4) store_t4[mem_car_sel_4] <= mem_entry_time_in_4;
    assign mem_entry_time_out   = store_t[mem_car_sel];
    assign mem_entry_time_out_4 = store_t4[mem_car_sel_4];

    // Write-pulse monitor, sampled on the falling edge.
    int         we_e_cnt = 0;
    int         we_c_cnt = 0;
    logic [1:0] last_e_sel, last_c_sel;
    logic [9:0] last_e_time, last_c_val, last_c_val4;
    bit         both_high = 1'b0;
    always @(negedge clk) begin
        if (mem_write_entry) begin
            we_e_cnt++;
            last_e_sel  = mem_car_sel;
            last_e_time = mem_entry_time_in;
        end
        if (mem_write_cost) begin
            we_c_cnt++;
            last_c_sel = mem_car_sel;
            last_c_val = mem_cost_in;
        end
        if (mem_write_cost_4) last_c_val4 = mem_cost_in_4;
        if ((mem_write_entry && mem_write_cost) || (mem_write_entry_4 && mem_write_cost_4))
            both_high = 1'b1;
    end

    // Reference model: which slots are taken, when they were entered, last fees charged.
    bit         m_occ  [4];
    logic [9:0] m_time [4];
    logic [9:0] m_fee, m_fee4;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] ref_fee(input int t_ex, input int t_en, input int rate);
        int el, units, f;
        el    = (t_ex - t_en + 1024) % 1024;
        units = (el < MIN_UNITS) ? MIN_UNITS : el;
        f     = units * rate;
        return (f > 1023) ? 10'd1023 : 10'(f);
    endfunction

    function automatic logic [2:0] model_occ();
        return {m_occ[2], m_occ[1], m_occ[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_occ[i] = 1'b0;
        m_fee  = 10'd0;
        m_fee4 = 10'd0;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_flags"}, {entry_ack, entry_nack, granted_car, exit_ack, exit_nack, full, busy, occupancy}, 0);
        check({pfx, "_fee_out"}, fee_out, 0);
        check({pfx, "_mem"}, {mem_car_sel, mem_write_entry, mem_write_cost, mem_entry_time_in, mem_cost_in}, 0);
        check({pfx, "_r4_flags"}, {entry_ack_4, entry_nack_4, granted_car_4, exit_ack_4, exit_nack_4,
                                   fee_out_4, occupancy_4, full_4, busy_4}, 0);
        check({pfx, "_r4_mem"}, {mem_car_sel_4, mem_write_entry_4, mem_write_cost_4,
                                 mem_entry_time_in_4, mem_cost_in_4}, 0);
    endtask

    task automatic pulse(input logic e, input logic x, input logic [1:0] car);
        @(negedge clk);
        entry_req = e;
        exit_req  = x;
        exit_car  = car;
        @(negedge clk);
        entry_req = 1'b0;
        exit_req  = 1'b0;
    endtask

    task automatic wait_resp(input bit is_exit, output bit got, output logic a, output logic n,
                             output logic [1:0] g);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (is_exit ? (exit_ack || exit_nack) : (entry_ack || entry_nack)) got = 1'b1;
        end
        a = is_exit ? exit_ack : entry_ack;
        n = is_exit ? exit_nack : entry_nack;
        g = granted_car;
    endtask

    task automatic do_entry(input logic [9:0] t);
        int         slot, e0;
        bit         got;
        logic       a, n;
        logic [1:0] g;
        slot = -1;
        for (int i = 0; i < 3; i++) if (!m_occ[i] && slot < 0) slot = i;
        time_now = t;
        e0 = we_e_cnt;
        pulse(1'b1, 1'b0, 2'd0);
        wait_resp(1'b0, got, a, n, g);
        check("entry_resp", got, 1);
        if (slot < 0) begin
            check("entry_nack", n, 1);
            check("entry_nack_nowr", we_e_cnt, e0);
            check("full_at_nack", full, 1);
        end else begin
            check("entry_ack", a, 1);
            check("granted_car", g, slot);
            check("entry_wr_cnt", we_e_cnt, e0 + 1);
            check("entry_wr_sel", last_e_sel, slot);
            check("entry_wr_time", last_e_time, t);
            m_occ[slot]  = 1'b1;
            m_time[slot] = t;
        end
        check("entry_occ", occupancy, model_occ());
        check("entry_full", full, &model_occ());
    endtask

    task automatic do_exit(input logic [1:0] car, input logic [9:0] t);
        int         c0;
        bit         got, valid;
        logic       a, n;
        logic [1:0] g;
        logic [9:0] fee, fee4;
        valid    = m_occ[car];
        time_now = t;
        c0 = we_c_cnt;
        pulse(1'b0, 1'b1, car);
        wait_resp(1'b1, got, a, n, g);
        check("exit_resp", got, 1);
        if (valid) begin
            fee  = ref_fee(t, m_time[car], 2);
            fee4 = ref_fee(t, m_time[car], 4);
            check("exit_ack", a, 1);
            check("exit_wr_cnt", we_c_cnt, c0 + 1);
            check("exit_wr_sel", last_c_sel, car);
            check("exit_wr_cost", last_c_val, fee);
            check("exit_wr_cost_r4", last_c_val4, fee4);
            m_occ[car] = 1'b0;
            m_fee  = fee;
            m_fee4 = fee4;
        end else begin
            check("exit_nack", n, 1);
            check("exit_nack_nowr", we_c_cnt, c0);
        end
        check("fee_out", fee_out, m_fee);
        check("fee_out_r4", fee_out_4, m_fee4);
        check("exit_occ", occupancy, model_occ());
    endtask

    initial begin
        int         c0, e0, ex_cyc, en_cyc;
        logic [1:0] g;

        reset     = 1'b1;
        time_now  = 10'd0;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        exit_car  = 2'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        do_entry(10'd100);
        do_entry(10'd1020);
        do_exit(2'd1, 10'd5);
        do_entry(10'd200);
        do_entry(10'd300);
        do_entry(10'd400);

        // Simultaneous entry and exit on a full lot: exit first, then the freed slot is granted.
        time_now = 10'd450;
        c0 = we_c_cnt;
        e0 = we_e_cnt;
        ex_cyc = -1;
        en_cyc = -1;
        g = 2'd0;
        pulse(1'b1, 1'b1, 2'd2);
        for (int i = 0; i < 30 && en_cyc < 0; i++) begin
            @(negedge clk);
            if (exit_ack && ex_cyc < 0) ex_cyc = i;
            if (entry_ack) begin
                en_cyc = i;
                g = granted_car;
            end
        end
        check("both_exit_seen", ex_cyc >= 0, 1);
        check("both_order", (ex_cyc >= 0) && (ex_cyc < en_cyc), 1);
        check("both_granted", g, 2);
        check("both_fee", fee_out, ref_fee(450, 300, 2));
        check("both_writes", {we_c_cnt - c0, we_e_cnt - e0}, {32'd1, 32'd1});
        check("both_entry_time", last_e_time, 450);
        check("both_occ", occupancy, 3'b111);
        m_time[2] = 10'd450;
        m_fee  = ref_fee(450, 300, 2);
        m_fee4 = ref_fee(450, 300, 4);

        do_exit(2'd3, 10'd10);
        do_exit(2'd0, 10'd100);
        do_exit(2'd0, 10'd50);
        do_entry(10'd100);
        do_exit(2'd0, 10'd600);

        // Reset while the exit sits in EXIT_CALC: the cost write must never appear.
        time_now = 10'd700;
        c0 = we_c_cnt;
        pulse(1'b0, 1'b1, 2'd1);
        @(negedge clk);
        @(negedge clk);
        check("busy_before_reset", busy, 1);
        reset = 1'b1;
        #1;
        check_zero("mid_reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("mid_reset_no_cost_wr", we_c_cnt, c0);
        check_zero("after_reset");

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1)
                do_entry(10'($urandom_range(0, 1023)));
            else
                do_exit(2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)));
        end

        check("no_dual_write_enable", both_high, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parking_ctrl.md
PARKING_CTRL -- requirements
Module: parking_ctrl

Interface
REQ-001 SHALL have parameter RATE, default 2, meaning cost units charged per elapsed time unit.
REQ-002 SHALL have parameter MIN_UNITS, default 1, meaning the minimum billable time units per stay.
REQ-003 SHALL have port clk, input, 1, the system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, the asynchronous, active-high reset.
REQ-005 SHALL have port time_now, input, 10, the free-running time counter, wrapping 1023->0.
REQ-006 SHALL have port entry_req, input, 1, a single-cycle pulse requesting a slot for an arriving car.
REQ-007 SHALL have port exit_req, input, 1, a single-cycle pulse requesting checkout.
REQ-008 SHALL have port exit_car, input, 2, the slot index to check out; it is sampled with exit_req.
REQ-009 SHALL have port mem_car_sel, output, 2, the slot-store select.
REQ-010 SHALL have port mem_write_entry, output, 1, the slot-store entry-time write enable.
REQ-011 SHALL have port mem_write_cost, output, 1, the slot-store cost write enable.
REQ-012 SHALL have port mem_entry_time_in, output, 10, the entry time to store.
REQ-013 SHALL have port mem_cost_in, output, 10, the cost to store.
REQ-014 SHALL have port mem_entry_time_out, input, 10, the combinational read of the stored entry time for mem_car_sel.
REQ-015 SHALL have port entry_ack, output, 1, a one-cycle pulse reporting that a slot was granted.
REQ-016 SHALL have port entry_nack, output, 1, a one-cycle pulse reporting that the lot is full.
REQ-017 SHALL have port granted_car, output, 2, the slot index granted; valid while entry_ack is high.
REQ-018 SHALL have port exit_ack, output, 1, a one-cycle pulse reporting that checkout is complete.
REQ-019 SHALL have port exit_nack, output, 1, a one-cycle pulse reporting an invalid exit: the slot is vacant or the index is 3.
REQ-020 SHALL have port fee_out, output, 10, the charged fee; it holds until the next exit_ack.
REQ-021 SHALL have port occupancy, output, 3, the per-slot occupied bitmask.
REQ-022 SHALL have port full, output, 1, asserted when occupancy==3'b111.
REQ-023 SHALL have port busy, output, 1, asserted when the FSM is not in IDLE.

Function
REQ-024 SHALL latch each request pulse into a one-deep pending flag (pend_entry, pend_exit plus the captured exit_car) whether or not busy; a second pulse of the same type while pending SHALL be dropped.
REQ-025 SHALL implement the FSM states IDLE, ENTRY_WR, EXIT_RD, EXIT_CALC, EXIT_WR and DONE.
REQ-026 SHALL, in IDLE with both flags pending, serve the exit first, so that the slot is freed before allocation.
REQ-027 SHALL handle an entry from IDLE as follows: if full, pulse entry_nack next cycle, clear pend_entry and stay in IDLE; otherwise go to ENTRY_WR.
REQ-028 SHALL, in ENTRY_WR, select the lowest-index free slot, drive it on mem_car_sel, assert mem_write_entry for one cycle with mem_entry_time_in equal to time_now sampled at the IDLE grant cycle, and set that occupancy bit.
REQ-029 SHALL handle an entry in DONE by pulsing entry_ack with granted_car, clearing pend_entry and returning to IDLE; entry latency is 2 cycles from IDLE to ack.
REQ-030 SHALL handle an exit from IDLE as follows: if the captured index is 3 or the slot is vacant, pulse exit_nack next cycle, clear pend_exit, leave the store untouched and stay in IDLE; otherwise go to EXIT_RD.
REQ-031 SHALL, in EXIT_RD, drive mem_car_sel with the exit index and register mem_entry_time_out and time_now.
REQ-032 SHALL, in EXIT_CALC, compute elapsed=(t_exit - t_entry) mod 1024, units=max(elapsed,MIN_UNITS) and fee=units*RATE, saturated to 1023.
REQ-033 SHALL, in EXIT_WR, assert mem_write_cost for one cycle with mem_cost_in=fee and clear the occupancy bit.
REQ-034 SHALL handle an exit in DONE by pulsing exit_ack, updating fee_out, clearing pend_exit and returning to IDLE; exit latency is 4 cycles from IDLE to ack.
REQ-035 SHALL register all outputs; the write enables SHALL never both be high, and each SHALL be high for at most one cycle per transaction.
REQ-036 SHALL, when reset is asserted mid-transaction, abort immediately with no further write pulse.

Reset
REQ-037 SHALL, on reset, set state=IDLE and clear every pending flag and occupancy bit; all outputs SHALL be 0 (full=0, busy=0, fee_out=0, mem_car_sel=0).

Verification
REQ-038 SHALL cover: at time_now=100, an entry_req on an empty lot -> mem_write_entry with car_sel=0 and time_in=100, then entry_ack with granted_car=0 and occupancy=001.
REQ-039 SHALL cover: three entries followed by a fourth -> the fourth gives entry_nack, full=1 and no write pulse.
REQ-040 SHALL cover: slot 1 entered at 1020 and exit_req at time_now=5 -> elapsed 9, fee 18, mem_cost_in=18 on car_sel=1, exit_ack, fee_out=18 and bit1 cleared.
REQ-041 SHALL cover: entry_req and exit_req(slot 2) on the same cycle with the lot full -> the exit completes first, then the entry is granted slot 2.
REQ-042 SHALL cover: exit_req with exit_car=3, and exit of a vacant slot -> exit_nack, no write, occupancy unchanged.
REQ-043 SHALL cover: same-cycle exit (elapsed 0) -> fee=2; RATE=4 with elapsed 500 -> fee saturates at 1023; reset asserted in EXIT_CALC -> no mem_write_cost and all outputs 0.
